// File: rtl/param_sync_ram.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// param_sync_ram
// Parametrised single-clock RAM with independent read and write ports, a
// per-bit write mask, write-first forwarding on same-address collisions, an
// optional output register stage and a sequential clear engine that zeroes
// every word one address per cycle.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset (memory contents untouched)
//   rd_en        read request
//   rd_addr      read address (addresses >= DEPTH return zero)
//   rd_data      read result, holds its last value while rd_valid is low
//   rd_valid     one-cycle pulse per accepted read
//   wr_en        write request
//   wr_addr      write address (addresses >= DEPTH are ignored)
//   wr_data      write data
//   wr_mask      per-bit write enable, 1 = update that bit
//   clear_start  request a full-memory clear
//   busy         high while the clear engine runs
// -----------------------------------------------------------------------------
module param_sync_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter bit OUT_REG    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic                  clear_start,
  output logic                  busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH-1);

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [DATA_WIDTH-1:0] mask
  );
    return (old_word & ~mask) | (new_word & mask);
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  state_t                state_r;
  state_t                state_next_s;
  logic [ADDR_WIDTH-1:0] clr_cnt_r;
  logic [ADDR_WIDTH-1:0] clr_cnt_next_s;
  logic                  busy_r;
  logic                  busy_next_s;

  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic [ADDR_WIDTH-1:0] wr_idx_s;
  logic [ADDR_WIDTH-1:0] rd_idx_s;
  logic                  wr_fire_s;
  logic                  rd_fire_s;
  logic                  collide_s;
  logic [DATA_WIDTH-1:0] merged_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;

  assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_EXT);

  // Port qualification, masked merge and write-first read selection.
  always_comb begin
    wr_idx_s  = {ADDR_WIDTH{1'b0}};
    rd_idx_s  = {ADDR_WIDTH{1'b0}};
    rd_word_s = {DATA_WIDTH{1'b0}};
    // Out-of-range addresses are steered to word 0 so the array is never
    // indexed past its end; the range flags decide whether the access counts.
    if (wr_in_range_s) begin
      wr_idx_s = wr_addr;
    end else begin
      wr_idx_s = {ADDR_WIDTH{1'b0}};
    end
    if (rd_in_range_s) begin
      rd_idx_s = rd_addr;
    end else begin
      rd_idx_s = {ADDR_WIDTH{1'b0}};
    end
    merged_s  = merge_word(mem_r[wr_idx_s], wr_data, wr_mask);
    wr_fire_s = (state_r == ST_IDLE) && wr_en && wr_in_range_s;
    rd_fire_s = (state_r == ST_IDLE) && rd_en;
    collide_s = wr_fire_s && (wr_addr == rd_addr);
    if (!rd_in_range_s) begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end else if (collide_s) begin
      rd_word_s = merged_s;
    end else begin
      rd_word_s = mem_r[rd_idx_s];
    end
  end

  // Storage array: the clear engine owns the write port while it runs;
  // contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[clr_cnt_r] <= {DATA_WIDTH{1'b0}};
    end else if (wr_fire_s) begin
      mem_r[wr_idx_s] <= merged_s;
    end
  end

  // Clear engine next-state: sweep 0..DEPTH-1 once, then return to idle.
  always_comb begin
    state_next_s   = state_r;
    clr_cnt_next_s = clr_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_start) begin
          state_next_s   = ST_CLEAR;
          clr_cnt_next_s = {ADDR_WIDTH{1'b0}};
        end else begin
          state_next_s   = ST_IDLE;
          clr_cnt_next_s = clr_cnt_r;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_r == LAST_ADDR) begin
          state_next_s   = ST_IDLE;
          clr_cnt_next_s = {ADDR_WIDTH{1'b0}};
        end else begin
          state_next_s   = ST_CLEAR;
          clr_cnt_next_s = clr_cnt_r + ADDR_WIDTH'(1'b1);
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        clr_cnt_next_s = {ADDR_WIDTH{1'b0}};
      end
    endcase
    busy_next_s = (state_next_s == ST_CLEAR);
  end

  // Clear engine state, counter and registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      clr_cnt_r <= {ADDR_WIDTH{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      clr_cnt_r <= clr_cnt_next_s;
      busy_r    <= busy_next_s;
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] stage_data_r;
      logic                  stage_valid_r;

      // Two-stage read path; the middle stage keeps draining during a clear
      // so reads accepted before it still complete with pre-clear data.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_data_r  <= {DATA_WIDTH{1'b0}};
          stage_valid_r <= 1'b0;
          rd_data_r     <= {DATA_WIDTH{1'b0}};
          rd_valid_r    <= 1'b0;
        end else begin
          stage_valid_r <= rd_fire_s;
          if (rd_fire_s) begin
            stage_data_r <= rd_word_s;
          end
          rd_valid_r <= stage_valid_r;
          if (stage_valid_r) begin
            rd_data_r <= stage_data_r;
          end
        end
      end
    end else begin : g_no_out_reg
      // Single-stage read path; rd_data only moves on an accepted read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_r  <= {DATA_WIDTH{1'b0}};
          rd_valid_r <= 1'b0;
        end else begin
          rd_valid_r <= rd_fire_s;
          if (rd_fire_s) begin
            rd_data_r <= rd_word_s;
          end
        end
      end
    end
  endgenerate

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_param_sync_ram.sv
`timescale 1ns/1ps
// Scoreboard bench for param_sync_ram: instance 0 uses the default
// parameters, instance 1 uses DEPTH=20, DATA_WIDTH=8, OUT_REG=1.
module tb_param_sync_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst         [2];
  logic        rd_en       [2];
  logic [4:0]  rd_addr     [2];
  logic        wr_en       [2];
  logic [4:0]  wr_addr     [2];
  logic [15:0] wr_data     [2];
  logic [15:0] wr_mask     [2];
  logic        clear_start [2];

  logic [15:0] rd_data_a;
  logic [7:0]  rd_data_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

  param_sync_ram u_dut_a (
    .clk(clk), .rst(rst[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_mask(wr_mask[0]),
    .clear_start(clear_start[0]), .busy(busy_a)
  );

  param_sync_ram #(.DATA_WIDTH(8), .DEPTH(20), .OUT_REG(1'b1)) u_dut_b (
    .clk(clk), .rst(rst[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1][7:0]), .wr_mask(wr_mask[1][7:0]),
    .clear_start(clear_start[1]), .busy(busy_b)
  );

  logic [15:0] rdd [2];
  logic        rdv [2];
  logic        bsy [2];
  assign rdd[0] = rd_data_a;
  assign rdd[1] = {8'h00, rd_data_b};
  assign rdv[0] = rd_valid_a;
  assign rdv[1] = rd_valid_b;
  assign bsy[0] = busy_a;
  assign bsy[1] = busy_b;

  // Reference model: plain arrays plus the window in which busy must be high.
  int          depth_m [2] = '{32, 20};
  int          lat_m   [2] = '{1, 2};
  logic [15:0] wmask_m [2] = '{16'hFFFF, 16'h00FF};
  logic [15:0] model   [2][32];
  logic [15:0] saved   [2][32];
  int          clr_at  [2];
  int          busy_to [2];
  logic [15:0] last_m  [2];

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %h, expected %h", name, d, cyc, act, exp);
    end
  endtask

  function automatic void push_exp(input int d, input logic [15:0] data, input int due);
    exp_t e;
    e.data = data;
    e.due  = due;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int d);
    if (d == 0) return q0.pop_front();
    else        return q1.pop_front();
  endfunction

  function automatic int qfront_due(input int d);
    return (d == 0) ? q0[0].due : q1[0].due;
  endfunction

  // Monitor: one pass per DUT per falling edge.
  task automatic monitor_one(input int d);
    exp_t e;
    logic exp_busy;
    exp_busy = (cyc >= clr_at[d]) && (cyc <= busy_to[d]);
    check("busy", d, 16'(bsy[d]), 16'(exp_busy));
    if (rdv[d]) begin
      if (qsize(d) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid dut%0d cyc %0d: got rd_valid=1 data %h, expected no read", d, cyc, rdd[d]);
      end else begin
        e = qpop(d);
        check("rd_data", d, rdd[d], e.data);
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL rd_latency dut%0d: got result at cyc %0d, expected cyc %0d", d, cyc, e.due);
        end
        last_m[d] = e.data;
      end
    end else begin
      check("rd_hold", d, rdd[d], last_m[d]);
      if (qsize(d) != 0 && qfront_due(d) < cyc) begin
        e = qpop(d);
        checks++;
        errors++;
        $display("FAIL missing_rd_valid dut%0d: no result by cyc %0d, expected %h at cyc %0d", d, cyc, e.data, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst[d]) monitor_one(d);
    end
  end

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      rd_en[d] = 1'b0; rd_addr[d] = 5'd0; wr_en[d] = 1'b0; wr_addr[d] = 5'd0;
      wr_data[d] = 16'h0000; wr_mask[d] = 16'h0000; clear_start[d] = 1'b0;
    end
  endtask

  // One cycle of stimulus for DUT d; the model is updated for the edge that
  // samples it (write applied before the read lookup gives write-first).
  task automatic op(input int d, input bit re, input int ra, input bit we, input int wa,
                    input logic [15:0] wd, input logic [15:0] wm, input bit cs);
    @(negedge clk);
    clear_inputs();
    rd_en[d] = re; rd_addr[d] = 5'(ra); wr_en[d] = we; wr_addr[d] = 5'(wa);
    wr_data[d] = wd; wr_mask[d] = wm; clear_start[d] = cs;
    if (cyc > busy_to[d]) begin
      if (we && wa < depth_m[d])
        model[d][wa] = ((model[d][wa] & ~wm) | (wd & wm)) & wmask_m[d];
      if (re)
        push_exp(d, (ra < depth_m[d]) ? model[d][ra] : 16'h0000, cyc + lat_m[d]);
      if (cs) begin
        for (int a = 0; a < 32; a++) begin
          saved[d][a] = model[d][a];
          model[d][a] = 16'h0000;
        end
        clr_at[d]  = cyc + 1;
        busy_to[d] = cyc + depth_m[d];
      end
    end
  endtask

  task automatic wr(input int d, input int a, input logic [15:0] data, input logic [15:0] mask);
    op(d, 1'b0, 0, 1'b1, a, data, mask, 1'b0);
  endtask

  task automatic rd(input int d, input int a);
    op(d, 1'b1, a, 1'b0, 0, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic clr(input int d);
    op(d, 1'b0, 0, 1'b0, 0, 16'h0000, 16'h0000, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clear_inputs();
    end
  endtask

  task automatic wait_idle(input int d);
    while (cyc <= busy_to[d]) idle(1);
  endtask

  // Asynchronous reset in the middle of a cycle; words below the clear
  // counter are zero, the rest keep their pre-clear contents.
  task automatic reset_mid(input int d);
    int n;
    @(negedge clk);
    clear_inputs();
    #2;
    rst[d] = 1'b1;
    #1;
    check("rst_busy", d, 16'(bsy[d]), 16'h0000);
    check("rst_rd_valid", d, 16'(rdv[d]), 16'h0000);
    check("rst_rd_data", d, rdd[d], 16'h0000);
    n = cyc - clr_at[d];
    for (int a = n; a < 32; a++) model[d][a] = saved[d][a];
    busy_to[d] = -1;
    last_m[d]  = 16'h0000;
    if (d == 0) q0.delete();
    else        q1.delete();
    #1;
    rst[d] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, hi, ra, wa;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; busy_to[i] = -1; clr_at[i] = 0; last_m[i] = 16'h0000;
      for (int a = 0; a < 32; a++) model[i][a] = 16'hxxxx;
    end
    clear_inputs();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_busy", i, 16'(bsy[i]), 16'h0000);
      check("reset_rd_valid", i, 16'(rdv[i]), 16'h0000);
      check("reset_rd_data", i, rdd[i], 16'h0000);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Basic write then read, one-cycle latency.
    wr(0, 3, 16'h1234, 16'hFFFF);
    wr(0, 31, 16'hBEEF, 16'hFFFF);
    rd(0, 3);
    rd(0, 31);
    idle(3);

    // Bit mask, and an all-zero mask leaving the word alone.
    wr(0, 5, 16'hFFFF, 16'hFFFF);
    wr(0, 5, 16'h0000, 16'h00F0);
    rd(0, 5);
    wr(0, 5, 16'hABCD, 16'h0000);
    rd(0, 5);
    idle(3);

    // Same-address collision is write-first.
    wr(0, 7, 16'hAAAA, 16'hFFFF);
    op(0, 1'b1, 7, 1'b1, 7, 16'h5555, 16'hFF00, 1'b0);
    rd(0, 7);
    idle(3);

    // Full clear; traffic during busy is ignored.
    for (int a = 0; a < 32; a++) wr(0, a, 16'(a * 37 + 1), 16'hFFFF);
    clr(0);
    op(0, 1'b1, 0, 1'b1, 0, 16'h1111, 16'hFFFF, 1'b0);
    rd(0, 3);
    wait_idle(0);
    for (int a = 0; a < 32; a++) rd(0, a);
    idle(3);

    // Reset ten cycles into a clear.
    for (int a = 0; a < 32; a++) wr(0, a, 16'hCAFE, 16'hFFFF);
    clr(0);
    repeat (10) @(negedge clk);
    reset_mid(0);
    for (int a = 0; a < 32; a++) rd(0, a);
    idle(3);

    // Narrow, non-power-of-two, registered-output instance.
    clr(1);
    wait_idle(1);
    wr(1, 19, 16'h003C, 16'h00FF);
    rd(1, 19);
    idle(3);
    wr(1, 25, 16'h0077, 16'h00FF);
    rd(1, 25);
    for (int a = 0; a < 20; a++) rd(1, a);
    op(1, 1'b1, 4, 1'b0, 0, 16'h0000, 16'h0000, 1'b1);
    wait_idle(1);
    rd(1, 4);
    idle(4);

    // Randomised traffic on both instances, biased towards collisions.
    for (int i = 0; i < 600; i++) begin
      d  = int'($urandom_range(0, 1));
      hi = (d == 0) ? 31 : 23;
      ra = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, hi));
      wa = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, hi));
      op(d, 1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, 16'($urandom),
         ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom), ($urandom_range(0, 79) == 0));
    end
    wait_idle(0);
    wait_idle(1);
    idle(6);

    for (int i = 0; i < 2; i++) begin
      checks++;
      if (qsize(i) != 0) begin
        errors++;
        $display("FAIL drain dut%0d: got %0d outstanding reads, expected 0", i, qsize(i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
